// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line synchroniser.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_WAIT_CLK,
        ST_SHIFT,
        ST_ACK,
        ST_RELEASE
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE          = 2'b00,
        ERR_START_TIMEOUT = 2'b01,
        ERR_XFER_TIMEOUT  = 2'b10,
        ERR_NO_ACK        = 2'b11
    } err_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // A line level must hold this many cycles before the filter accepts it.
    localparam int unsigned FILTER_CYCLES = 8;

    // Split the divide so large timeouts at 50 MHz stay inside 32 bits.
    function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned clk_hz);
        return (us * (clk_hz / 1000)) / 1000;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [8:0] make_frame(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte handshake and status bundle between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rx_inhibit;
    logic       done;
    logic       error;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_inhibit, done, error, err_code
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_inhibit, done, error, err_code
    );

endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchroniser and stability filter for the PS/2 clock and data pins,
// with a one-cycle strobe on each filtered clock falling edge.
module ps2_host_tx_line_sync
    import ps2_host_tx_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_async_i,
    input  logic ps2_dat_async_i,
    output logic ps2_clk_o,
    output logic ps2_dat_o,
    output logic clk_fall_o
);

    localparam int unsigned CW = $clog2(FILTER_CYCLES);

    // Bit 0 carries the clock line, bit 1 the data line.
    logic [1:0]         meta_q, sync_q, filt_q, filt_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic               fall_q, fall_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
            filt_q <= 2'b11;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= {ps2_dat_async_i, ps2_clk_async_i};
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= fall_d;
        end
    end

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(FILTER_CYCLES - 1)) begin
                cnt_d[i]  = '0;
                filt_d[i] = sync_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        fall_d = filt_q[0] & ~filt_d[0];
    end

    assign ps2_clk_o  = filt_q[0];
    assign ps2_dat_o  = filt_q[1];
    assign clk_fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: requests the bus by holding clock low, then shifts
// one command byte out on device-generated clocks and checks the device ack.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 50_000_000,
    parameter int unsigned INHIBIT_US       = 120,
    parameter int unsigned REQ_US           = 10,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned XFER_TIMEOUT_US  = 2000
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_async_i,
    input  logic         ps2_dat_async_i,
    output logic         ps2_clk_oe_o,
    output logic         ps2_dat_oe_o
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(INHIBIT_US, CLK_HZ);
    localparam int unsigned REQ_CYC     = us_to_cycles(REQ_US, CLK_HZ);
    localparam int unsigned START_CYC   = us_to_cycles(START_TIMEOUT_US, CLK_HZ);
    localparam int unsigned XFER_CYC    = us_to_cycles(XFER_TIMEOUT_US, CLK_HZ);
    localparam int unsigned MAX_CYC     = max_u(max_u(INHIBIT_CYC, REQ_CYC), max_u(START_CYC, XFER_CYC));
    localparam int unsigned TW          = $clog2(MAX_CYC + 1);

    // Timer counts down to zero inclusive, so each load is one less than the period.
    localparam logic [TW-1:0] INHIBIT_LD = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] REQ_LD     = TW'(REQ_CYC - 1);
    localparam logic [TW-1:0] START_LD   = TW'(START_CYC - 1);
    localparam logic [TW-1:0] XFER_LD    = TW'(XFER_CYC - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    frame_q, frame_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    err_e          err_code_q, err_code_d;
    logic          fail;
    err_e          fail_code;
    logic          line_clk, line_dat, clk_fall;
    logic          timer_zero;

    ps2_host_tx_line_sync u_line_sync (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .ps2_clk_async_i (ps2_clk_async_i),
        .ps2_dat_async_i (ps2_dat_async_i),
        .ps2_clk_o       (line_clk),
        .ps2_dat_o       (line_dat),
        .clk_fall_o      (clk_fall)
    );

    assign timer_zero = (timer_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_code_d = err_code_q;
        fail       = 1'b0;
        fail_code  = ERR_NONE;

        unique case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (bus.tx_valid) begin
                    state_d  = ST_INHIBIT;
                    frame_d  = make_frame(bus.tx_data);
                    timer_d  = INHIBIT_LD;
                    clk_oe_d = 1'b1;
                end
            end
            ST_INHIBIT: begin
                if (timer_zero) begin
                    state_d  = ST_REQ;
                    timer_d  = REQ_LD;
                    dat_oe_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_REQ: begin
                if (timer_zero) begin
                    state_d  = ST_WAIT_CLK;
                    timer_d  = START_LD;
                    clk_oe_d = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_WAIT_CLK: begin
                if (clk_fall) begin
                    state_d  = ST_SHIFT;
                    bit_d    = '0;
                    dat_oe_d = ~frame_q[0];
                    timer_d  = XFER_LD;
                end else if (timer_zero) begin
                    fail      = 1'b1;
                    fail_code = ERR_START_TIMEOUT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    if (bit_q == 4'd8) begin
                        dat_oe_d = 1'b0;
                        state_d  = ST_ACK;
                    end else begin
                        bit_d    = bit_q + 4'd1;
                        dat_oe_d = ~frame_q[bit_q + 4'd1];
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (!line_dat) begin
                        state_d = ST_RELEASE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_NO_ACK;
                    end
                end
            end
            ST_RELEASE: begin
                if (line_clk && line_dat) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // One shared budget covers everything from the first device edge to the ack.
        if (!fail && (state_q inside {ST_SHIFT, ST_ACK, ST_RELEASE}) && (state_d == state_q)) begin
            if (timer_zero) begin
                fail      = 1'b1;
                fail_code = ERR_XFER_TIMEOUT;
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end

        if (fail) begin
            state_d    = ST_IDLE;
            clk_oe_d   = 1'b0;
            dat_oe_d   = 1'b0;
            error_d    = 1'b1;
            err_code_d = fail_code;
        end
    end

    assign ps2_clk_oe_o   = clk_oe_q;
    assign ps2_dat_oe_o   = dat_oe_q;
    assign bus.tx_ready   = (state_q == ST_IDLE);
    assign bus.rx_inhibit = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.err_code   = err_code_q;

endmodule
